sync_debounce: RTL
==================

# sync_debounce

Conditions a raw, asynchronous single-bit input (push-button, external strobe, slow off-chip level) before it reaches the team's registered D flip-flop stage and downstream logic. The block synchronises the input into the `clk` domain with a multi-stage flop chain, rejects pulses shorter than a programmable number of cycles, and presents a clean level plus one-cycle rise and fall pulses. Its `dout` drives the `D` input of the next registered stage directly.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flop count; legal range 2..4.
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a new level must persist before it is accepted; legal range 1..2**`CNT_W`.
- `CNT_W`, default 8: debounce counter width.

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset; 0 clears all state immediately; release is synchronous to `clk` at system level.
- `din`  input  1  raw asynchronous input; no timing relationship to `clk`.
- `dout`  output  1  debounced, synchronised level.
- `rise`  output  1  one-cycle pulse on the edge where `dout` goes 0→1.
- `fall`  output  1  one-cycle pulse on the edge where `dout` goes 1→0.
- `busy`  output  1  high while a candidate level change is being qualified.

## Operation
- Synchroniser: a `SYNC_STAGES`-deep shift chain. Stage 0 samples `din`; the last stage (`s_out`) is the only signal used downstream. No logic sits between stages.
- FSM states are IDLE and CHECK, with a counter `cnt` of width `CNT_W`.
- IDLE, `s_out == dout`: hold, `cnt = 0`.
- IDLE, `s_out != dout`:
  - `DEBOUNCE_CYCLES == 1`: commit immediately (see commit below).
  - Otherwise: go to CHECK, `cnt = 1`.
- CHECK, `s_out != dout`, `cnt == DEBOUNCE_CYCLES-1`: commit, meaning `dout <= s_out`, pulse `rise` or `fall` to match the new level, `cnt = 0`, go to IDLE.
- CHECK, `s_out != dout`, otherwise: `cnt = cnt + 1`, stay in CHECK.
- CHECK, `s_out == dout`: abort to IDLE with `cnt = 0`. No output change and no pulse. The glitch is discarded.
- `busy` is high exactly when the state is CHECK (registered).
- `rise` and `fall` are registered, never both high, and each lasts exactly one cycle per commit.
- Counter arithmetic is unsigned and never wraps, because it is cleared on commit or abort before reaching `DEBOUNCE_CYCLES`.

## Timing
- Reset values: all synchroniser stages 0, state IDLE, `cnt` 0, `dout` 0, `rise` 0, `fall` 0, `busy` 0.
- When `reset` is asserted mid-qualification, the block clears at once. No pulse is emitted, and the pending change is lost.
- First active edge is the first rising `clk` after `reset` is released.
- Latency definition: `din` changes and is stable before edge k, and stage 0 captures it at edge k.
  - `s_out` reflects the change after edge k+`SYNC_STAGES`-1.
  - The first mismatch is seen at edge k+`SYNC_STAGES`.
  - `dout`, `rise` and `fall` update at edge k+`SYNC_STAGES`+`DEBOUNCE_CYCLES`-1.
  - Defaults give k+5.
- `busy` rises at edge k+`SYNC_STAGES` (only when `DEBOUNCE_CYCLES` > 1) and falls at the commit edge.
- Rejection rule: a `din` level held fewer than `DEBOUNCE_CYCLES` cycles, as seen at `s_out`, produces no change on any output except `busy`.
- Back-to-back changes: a new opposite transition is qualified only after the previous commit. The minimum spacing between two `dout` edges is `DEBOUNCE_CYCLES` cycles.
- If `din` is held at 1 through reset release, `dout` rises at edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`-1 after the first active edge, with a `rise` pulse.

## Test plan
- Reset and hold: with `reset`=0 and `din`=1, all outputs must stay 0. Release `reset` before edge 0 with `din`=1 held: `dout`=1 and `rise`=1 must appear at edge 5 (defaults), with `rise` low again at edge 6.
- Clean edge: with the block settled at 0, drive `din` 0→1 before edge 10 and hold.
  - `busy` must be 1 from edge 12.
  - `dout`=1 and `rise`=1 must appear at edge 15.
  - `busy`=0 after edge 15.
  - Then drive 1→0 before edge 30 and hold: `fall`=1 and `dout`=0 must appear at edge 35.
- Glitch rejection: pulse `din` high for 3 cycles. Required: `busy` high for 3 cycles, `dout` stays 0, `rise` and `fall` never asserted.
- Boundary: pulse `din` high for exactly 4 cycles. Required: `dout`=1 at the 4th mismatch edge, with a `rise` pulse.
- Reset mid-CHECK: assert `reset` two cycles after `busy` rises. Required: `busy`, `cnt` and `dout` are 0 immediately and asynchronously, and no `rise` pulse follows release.
- Parameter sweep: repeat the clean-edge case with `SYNC_STAGES`=3 and `DEBOUNCE_CYCLES`=1. Required: the commit occurs at edge k+3 and `busy` never asserts.

Source files
------------

// File: rtl/sync_debounce.sv
// sync_debounce: synchronises a raw asynchronous level into the clk domain,
// discards pulses shorter than DEBOUNCE_CYCLES, and presents a clean level
// plus one-cycle rise/fall pulses.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | synchronised input agrees with dout; nothing pending
// CHECK | synchronised input differs from dout; counting how long it holds
module sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  // Last count value before a candidate level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_out;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   commit;

  // Synchroniser chain: plain shift, nothing between the stages.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  // Synchroniser registers; cleared to 0 on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign s_out = sync_q[SYNC_STAGES-1];

  // Next-state, counter and output decode for the qualification FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    commit  = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_out != dout_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            commit = 1'b1;
          end else begin
            state_d = CHECK;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      CHECK: begin
        if (s_out == dout_q) begin
          // Glitch ended before qualifying: drop it silently.
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          commit  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (commit) begin
      dout_d = s_out;
      rise_d = s_out;
      fall_d = ~s_out;
    end
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == CHECK);

endmodule
